// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execution-unit state encoding.
// Used by the ALU decoder, the combinational core and the execution unit.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    function automatic logic alu_code_legal(input logic [2:0] code);
        logic legal;
        case (code)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
            default:                                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_exec_unit_core.sv
// Purely combinational ALU: one shared adder serves ADD, SUB and SLT.
// Unsupported codes yield a zero result with only the illegal flag set.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    logic [WIDTH-1:0] b_eff_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic             ovf_s;

    // Adder operand selection: subtraction is A + ~B + 1.
    always_comb begin
        b_eff_s = b;
        cin_s   = 1'b0;
        case (code)
            ALU_SUB, ALU_SLT: begin
                b_eff_s = ~b;
                cin_s   = 1'b1;
            end
            default: begin
                b_eff_s = b;
                cin_s   = 1'b0;
            end
        endcase
    end

    assign sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    assign ovf_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);

    // Result and flag selection; SLT uses N^V of the subtraction.
    always_comb begin
        result   = {WIDTH{1'b0}};
        carry    = 1'b0;
        overflow = 1'b0;
        illegal  = !alu_code_legal(code);
        case (code)
            ALU_ADD, ALU_SUB: begin
                result   = sum_s[WIDTH-1:0];
                carry    = sum_s[WIDTH];
                overflow = ovf_s;
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: begin
                result   = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ ovf_s};
                carry    = sum_s[WIDTH];
                overflow = ovf_s;
            end
            default: begin
                result   = {WIDTH{1'b0}};
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with valid/ready handshakes on both sides.
// Result and flags are registered on entry to DONE and held until taken.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int             CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(LATENCY - 1);

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [2:0]       code_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             neg_r;
    logic             carry_r;
    logic             ovf_r;
    logic             ill_r;

    logic             accept_s;
    logic             load_s;
    logic [2:0]       core_code_s;
    logic [WIDTH-1:0] core_a_s;
    logic [WIDTH-1:0] core_b_s;
    logic [WIDTH-1:0] core_res_s;
    logic             core_carry_s;
    logic             core_ovf_s;
    logic             core_ill_s;

    // Ready depends on state; in DONE the slot frees only when downstream takes it.
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            ST_IDLE: in_ready = 1'b1;
            ST_EXEC: in_ready = 1'b0;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_r == ST_DONE);

    // With LATENCY==1 the result is captured at the accept edge from the live inputs.
    always_comb begin
        if (state_r == ST_EXEC) begin
            core_code_s = code_r;
            core_a_s    = a_r;
            core_b_s    = b_r;
        end else begin
            core_code_s = ALUControl;
            core_a_s    = SrcA;
            core_b_s    = SrcB;
        end
    end

    assign load_s = (accept_s && (LATENCY == 1)) ||
                    ((state_r == ST_EXEC) && (cnt_r == CNT_ONE));

    alu_core #(.WIDTH(WIDTH)) u_core (
        .code     (core_code_s),
        .a        (core_a_s),
        .b        (core_b_s),
        .result   (core_res_s),
        .carry    (core_carry_s),
        .overflow (core_ovf_s),
        .illegal  (core_ill_s)
    );

    // Handshake FSM, latency counter and operand latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            code_r  <= 3'b000;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            code_r  <= ALUControl;
            a_r     <= SrcA;
            b_r     <= SrcB;
            cnt_r   <= CNT_INIT;
            state_r <= (LATENCY == 1) ? ST_DONE : ST_EXEC;
        end else begin
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_EXEC: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Result and flag registers, written only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
            neg_r    <= 1'b0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
            ill_r    <= 1'b0;
        end else if (load_s) begin
            result_r <= core_res_s;
            zero_r   <= (core_res_s == {WIDTH{1'b0}});
            neg_r    <= core_res_s[WIDTH-1];
            carry_r  <= core_carry_s;
            ovf_r    <= core_ovf_s;
            ill_r    <= core_ill_s;
        end
    end

    assign ALUResult = result_r;
    assign Zero      = zero_r;
    assign Negative  = neg_r;
    assign Carry     = carry_r;
    assign Overflow  = ovf_r;
    assign Illegal   = ill_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench: two units (LATENCY 1 and 3) checked against
// an arithmetic reference model, plus directed corner cases.
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        il;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_s  [2];
    logic        in_ready_s  [2];
    logic [2:0]  code_s      [2];
    logic [31:0] srca_s      [2];
    logic [31:0] srcb_s      [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];
    logic [31:0] result_s    [2];
    logic        zero_s      [2];
    logic        neg_s       [2];
    logic        carry_s     [2];
    logic        ovf_s       [2];
    logic        ill_s       [2];

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t last [2];
    exp_t pend [2];

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .ALUControl(code_s[0]), .SrcA(srca_s[0]), .SrcB(srcb_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .ALUResult(result_s[0]),
        .Zero(zero_s[0]), .Negative(neg_s[0]), .Carry(carry_s[0]),
        .Overflow(ovf_s[0]), .Illegal(ill_s[0])
    );

    alu_exec_unit #(.WIDTH(32), .LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .ALUControl(code_s[1]), .SrcA(srca_s[1]), .SrcB(srcb_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .ALUResult(result_s[1]),
        .Zero(zero_s[1]), .Negative(neg_s[1]), .Carry(carry_s[1]),
        .Overflow(ovf_s[1]), .Illegal(ill_s[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Reference model from the arithmetic definition of each operation.
    function automatic exp_t model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        exp_t              m;
        longint            sa = longint'($signed(a));
        longint            sb = longint'($signed(b));
        longint unsigned   ua = 64'(a);
        longint unsigned   ub = 64'(b);
        longint            s;
        m = '{res: 32'h0, c: 1'b0, v: 1'b0, il: 1'b0};
        case (code)
            3'b000: begin
                m.res = a + b;
                m.c   = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
                s     = sa + sb;
                m.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'b001, 3'b101: begin
                s     = sa - sb;
                m.c   = (a >= b);
                m.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                m.res = (code == 3'b001) ? (a - b) : ((sa < sb) ? 32'd1 : 32'd0);
            end
            3'b010: m.res = a & b;
            3'b011: m.res = a | b;
            default: m.il = 1'b1;
        endcase
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_out(input int i, input string tag, input exp_t e);
        chk({tag, ".res"}, result_s[i], e.res);
        chk({tag, ".zero"}, 32'(zero_s[i]), 32'(e.res == 32'h0));
        chk({tag, ".neg"}, 32'(neg_s[i]), 32'(e.res[31]));
        chk({tag, ".carry"}, 32'(carry_s[i]), 32'(e.c));
        chk({tag, ".ovf"}, 32'(ovf_s[i]), 32'(e.v));
        chk({tag, ".ill"}, 32'(ill_s[i]), 32'(e.il));
    endtask

    // Called at a negedge with the unit in IDLE or DONE; returns at the negedge after accept.
    task automatic issue(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid_s[i]  = 1'b1;
        code_s[i]      = c;
        srca_s[i]      = a;
        srcb_s[i]      = b;
        out_ready_s[i] = 1'b1;
        #1;
        chk("accept.in_ready", 32'(in_ready_s[i]), 32'd1);
        pend[i] = model(c, a, b);
        @(posedge clk);
        @(negedge clk);
        in_valid_s[i]  = 1'b0;
        out_ready_s[i] = 1'b0;
    endtask

    task automatic finish_op(input int i, input int hold);
        for (int k = 1; k <= lat(i); k++) begin
            if (k > 1) @(negedge clk);
            if (k < lat(i)) begin
                chk("exec.out_valid", 32'(out_valid_s[i]), 32'd0);
                chk("exec.in_ready", 32'(in_ready_s[i]), 32'd0);
                chk_out(i, "exec", last[i]);
            end else begin
                chk("done.out_valid", 32'(out_valid_s[i]), 32'd1);
                chk_out(i, "done", pend[i]);
            end
        end
        last[i] = pend[i];
        for (int h = 0; h < hold; h++) begin
            in_valid_s[i] = 1'b1;
            code_s[i]     = 3'($urandom_range(0, 7));
            srca_s[i]     = $urandom;
            srcb_s[i]     = $urandom;
            #1;
            chk("hold.in_ready", 32'(in_ready_s[i]), 32'd0);
            @(negedge clk);
            chk("hold.out_valid", 32'(out_valid_s[i]), 32'd1);
            chk_out(i, "hold", last[i]);
        end
        in_valid_s[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        out_ready_s[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_s[i] = 1'b0;
        chk("idle.out_valid", 32'(out_valid_s[i]), 32'd0);
        chk("idle.in_ready", 32'(in_ready_s[i]), 32'd1);
        chk_out(i, "idle", last[i]);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        exp_t zero_e;
        zero_e = '{res: 32'h0, c: 1'b0, v: 1'b0, il: 1'b0};
        for (int i = 0; i < 2; i++) begin
            in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0; code_s[i] = 3'b000;
            srca_s[i] = 32'h0; srcb_s[i] = 32'h0; last[i] = zero_e; pend[i] = zero_e;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst.out_valid", 32'(out_valid_s[i]), 32'd0);
            chk("rst.in_ready", 32'(in_ready_s[i]), 32'd1);
            chk_out(i, "rst", zero_e);
        end
        rst = 1'b0;
        @(negedge clk);

        // LATENCY 1 directed: overflow, equality, SLT both signs, illegal code.
        issue(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        finish_op(0, 0);
        chk("t1.res", result_s[0], 32'h8000_0000);
        chk("t1.ovf", 32'(ovf_s[0]), 32'd1);
        drain(0);
        issue(0, ALU_SUB, 32'd5, 32'd5);
        finish_op(0, 0);
        chk("t2.zero", 32'(zero_s[0]), 32'd1);
        chk("t2.carry", 32'(carry_s[0]), 32'd1);
        issue(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        finish_op(0, 1);
        chk("t2.slt_neg", result_s[0], 32'd1);
        issue(0, ALU_SLT, 32'd1, 32'hFFFF_FFFF);
        finish_op(0, 0);
        chk("t2.slt_pos", result_s[0], 32'd0);
        issue(0, 3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op(0, 0);
        chk("t5.ill", 32'(ill_s[0]), 32'd1);
        drain(0);

        // LATENCY 3 directed: hold with ignored inputs, then back-to-back accept.
        issue(1, ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        finish_op(1, 4);
        chk("t3.res", result_s[1], 32'hF000_F000);
        issue(1, ALU_OR, 32'h1, 32'h2);
        finish_op(1, 0);
        chk("t4.res", result_s[1], 32'h3);

        // Reset one cycle after accept discards the in-flight operation.
        issue(1, ALU_ADD, 32'h1234_5678, 32'h1111_1111);
        rst = 1'b1;
        #1;
        chk("t6.out_valid", 32'(out_valid_s[1]), 32'd0);
        chk_out(1, "t6.rst", zero_e);
        last[0] = zero_e;
        last[1] = zero_e;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6.in_ready", 32'(in_ready_s[1]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6.no_stale", 32'(out_valid_s[1]), 32'd0);
            chk_out(1, "t6.idle", zero_e);
        end

        // Random operations across both units.
        for (int n = 0; n < 300; n++) begin
            int i;
            i = int'($urandom_range(0, 1));
            issue(i, 3'($urandom_range(0, 7)), rnd_val(), rnd_val());
            finish_op(i, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 1) == 0) drain(i);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 3-bit ALUControl code produced by the control unit's ALU decoder.
- Accepts one operation (code plus two operands) over a valid/ready handshake and computes it over a parameterised number of cycles.
- Holds the registered result and flags until the downstream stage takes them, so the single-cycle datapath can be moved to a multi-cycle or stalled pipeline.

Parameters:
- WIDTH, 32, operand and result width in bits (minimum 2).
- LATENCY, 1, cycles from accept to out_valid (minimum 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation this cycle.
- ALUControl  input  3  operation code, sampled on accept.
- SrcA  input  WIDTH  operand A, sampled on accept.
- SrcB  input  WIDTH  operand B, sampled on accept.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  downstream takes the result.
- ALUResult  output  WIDTH  registered result.
- Zero  output  1  ALUResult == 0.
- Negative  output  1  ALUResult[WIDTH-1].
- Carry  output  1  adder carry-out (see rules).
- Overflow  output  1  signed overflow of the adder.
- Illegal  output  1  unsupported code was executed.

Behaviour:
- Codes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 AND.
  - 011 OR.
  - 101 SLT: result = {WIDTH-1 zeros, N^V} of A-B, signed.
  - 100, 110, 111: illegal. Result 0, Illegal=1, Carry=Overflow=0.
- Flags:
  - ADD/SUB/SLT: Carry = adder carry-out. For SUB/SLT that is the no-borrow bit, 1 when A>=B unsigned.
  - ADD/SUB/SLT: Overflow = standard two's-complement overflow of that add/sub.
  - AND/OR: Carry=0, Overflow=0.
  - Zero and Negative always reflect the registered ALUResult.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EXEC: in_ready=0, out_valid=0; cycle counter running.
  - DONE: out_valid=1; in_ready=out_ready.
- Transitions:
  - IDLE & in_valid: latch code and operands. Go to DONE if LATENCY==1, else to EXEC with counter=LATENCY-1.
  - EXEC: decrement counter each cycle. At counter==1, register result and flags and go to DONE.
  - DONE & out_ready & !in_valid: go to IDLE.
  - DONE & out_ready & in_valid: back-to-back accept; relatch and proceed as from IDLE in the same cycle.
  - DONE & !out_ready: hold. ALUResult and all flags stay stable and out_valid stays 1 until out_ready. Inputs are ignored.
- Latency: out_valid asserts exactly LATENCY cycles after the accept edge.
- Throughput: with out_ready tied high, one op per LATENCY cycles.
- Result and flags update only on entry to DONE. Their values in IDLE and EXEC are the last completed result (0 after reset).
- Reset, asynchronous and at any time including mid-EXEC or DONE:
  - state=IDLE, counter=0.
  - ALUResult=0, Zero=1, Negative=0, Carry=0, Overflow=0, Illegal=0, out_valid=0.
  - In-flight operation is discarded.
- Arithmetic is WIDTH-bit modulo. No X propagation from unsupported codes.

Decomposition:
- Shared package alu_pkg:
  - localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - State encoding for IDLE/EXEC/DONE.
  - The decoder also uses these code constants.
- One natural sub-module: alu_core, purely combinational.
  - Inputs: code, A, B.
  - Outputs: result, carry, overflow, illegal.
  - alu_exec_unit instantiates it on the latched operands and owns the FSM, counter and output registers.

Test Plan:
1. LATENCY=1; ADD A=0x7FFFFFFF, B=1, out_ready=1 → next cycle out_valid=1, ALUResult=0x80000000, Negative=1, Overflow=1, Carry=0, Zero=0.
2. SUB A=5, B=5 → ALUResult=0, Zero=1, Carry=1. SLT A=0xFFFFFFFF (-1), B=1 → ALUResult=1. SLT A=1, B=0xFFFFFFFF → 0.
3. LATENCY=3; accept AND 0xF0F0F0F0 & 0xFF00FF00 → out_valid exactly 3 cycles later, ALUResult=0xF000F000. Hold out_ready=0 for 4 cycles → outputs stable, in_ready=0, new in_valid ignored.
4. Back-to-back: in DONE with out_ready=1 and in_valid=1 carrying OR 0x1|0x2 → accepted that cycle, next result 0x3, no idle bubble.
5. ALUControl=3'b110, A=B=0xFFFFFFFF → ALUResult=0, Illegal=1, Zero=1, Carry=Overflow=0, handshake completes normally.
6. LATENCY=3; assert rst one cycle after accept → immediately out_valid=0, ALUResult=0, Zero=1, in_ready=1 after release. No stale result ever appears.
